// File: rtl/oc8051_cxrom_fetch_server_if.sv
// Code-ROM word fetch bus: request/response handshake toward the consumer
// plus the byte-wide backing ROM port. The slave side is the fetch server.
interface oc8051_cxrom_fetch_server_if;
    logic        flush;
    logic        req_valid;
    logic [15:0] req_addr;
    logic        req_ready;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [15:0] rsp_addr;
    logic        rsp_err;
    logic        mem_rd;
    logic [15:0] mem_addr;
    logic [7:0]  mem_data_in;
    logic        mem_ack;

    modport slave (
        input  flush, req_valid, req_addr, rsp_ready, mem_data_in, mem_ack,
        output req_ready, rsp_valid, rsp_data, rsp_addr, rsp_err, mem_rd, mem_addr
    );

    modport master (
        output flush, req_valid, req_addr, rsp_ready, mem_data_in, mem_ack,
        input  req_ready, rsp_valid, rsp_data, rsp_addr, rsp_err, mem_rd, mem_addr
    );
endinterface

// File: rtl/oc8051_cxrom_fetch_server.sv
// Code-ROM word fetch server: assembles four consecutive ROM bytes into a
// little-endian 32-bit word, with a one-entry word buffer for repeat fetches
// and a per-byte ack timeout that turns into an error response.
module oc8051_cxrom_fetch_server #(
    parameter int TIMEOUT = 256
) (
    input  logic                           clk,
    input  logic                           rst,
    oc8051_cxrom_fetch_server_if.slave     bus
);
    typedef enum logic [1:0] {IDLE, FETCH, RESP} state_t;

    // Timeout fires on the wait cycle that brings the count up to TIMEOUT.
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic        req_ready_q, req_ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_err_q, rsp_err_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic [15:0] rsp_addr_q, rsp_addr_d;
    logic        mem_rd_q, mem_rd_d;
    logic [15:0] mem_addr_q, mem_addr_d;
    logic        buf_valid_q, buf_valid_d;
    logic [15:0] buf_addr_q, buf_addr_d;
    logic [31:0] buf_word_q, buf_word_d;
    logic [15:0] fetch_addr_q, fetch_addr_d;
    logic [31:0] word_q, word_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [15:0] tmo_q, tmo_d;
    logic        fetch_flushed_q, fetch_flushed_d;

    // Next-state logic for the IDLE/FETCH/RESP controller and the word buffer.
    always_comb begin
        state_d         = state_q;
        req_ready_d     = req_ready_q;
        rsp_valid_d     = rsp_valid_q;
        rsp_err_d       = rsp_err_q;
        rsp_data_d      = rsp_data_q;
        rsp_addr_d      = rsp_addr_q;
        mem_rd_d        = mem_rd_q;
        mem_addr_d      = mem_addr_q;
        buf_valid_d     = buf_valid_q;
        buf_addr_d      = buf_addr_q;
        buf_word_d      = buf_word_q;
        fetch_addr_d    = fetch_addr_q;
        word_d          = word_q;
        cnt_d           = cnt_q;
        tmo_d           = tmo_q;
        fetch_flushed_d = fetch_flushed_q;

        if (bus.flush) begin
            buf_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    req_ready_d = 1'b0;
                    // A flush on the accepting edge forces a miss.
                    if (buf_valid_q && !bus.flush && (buf_addr_q == bus.req_addr)) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b0;
                        rsp_data_d  = buf_word_q;
                        rsp_addr_d  = bus.req_addr;
                    end else begin
                        state_d         = FETCH;
                        fetch_addr_d    = bus.req_addr;
                        cnt_d           = 2'd0;
                        tmo_d           = 16'd0;
                        word_d          = 32'd0;
                        fetch_flushed_d = 1'b0;
                        mem_rd_d        = 1'b1;
                        mem_addr_d      = bus.req_addr;
                    end
                end
            end

            FETCH: begin
                if (bus.flush) begin
                    fetch_flushed_d = 1'b1;
                end
                if (bus.mem_ack) begin
                    word_d[{cnt_q, 3'b000} +: 8] = bus.mem_data_in;
                    tmo_d = 16'd0;
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d     = RESP;
                        mem_rd_d    = 1'b0;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b0;
                        rsp_data_d  = word_d;
                        rsp_addr_d  = fetch_addr_q;
                        // A flush seen at any point of this fetch keeps it out of the buffer.
                        if (!bus.flush && !fetch_flushed_q) begin
                            buf_valid_d = 1'b1;
                            buf_addr_d  = fetch_addr_q;
                            buf_word_d  = word_d;
                        end
                    end else begin
                        mem_addr_d = fetch_addr_q + {14'd0, cnt_q + 2'd1};
                    end
                end else if (tmo_q == TMO_LAST) begin
                    state_d     = RESP;
                    mem_rd_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_data_d  = 32'd0;
                    rsp_addr_d  = fetch_addr_q;
                    tmo_d       = 16'd0;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
            end

            RESP: begin
                if (bus.rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    rsp_err_d   = 1'b0;
                    req_ready_d = 1'b1;
                end
            end

            default: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
                rsp_valid_d = 1'b0;
                mem_rd_d    = 1'b0;
            end
        endcase
    end

    // State and registered outputs, asynchronously cleared by rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            req_ready_q     <= 1'b1;
            rsp_valid_q     <= 1'b0;
            rsp_err_q       <= 1'b0;
            rsp_data_q      <= 32'd0;
            rsp_addr_q      <= 16'd0;
            mem_rd_q        <= 1'b0;
            mem_addr_q      <= 16'd0;
            buf_valid_q     <= 1'b0;
            buf_addr_q      <= 16'd0;
            buf_word_q      <= 32'd0;
            fetch_addr_q    <= 16'd0;
            word_q          <= 32'd0;
            cnt_q           <= 2'd0;
            tmo_q           <= 16'd0;
            fetch_flushed_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            req_ready_q     <= req_ready_d;
            rsp_valid_q     <= rsp_valid_d;
            rsp_err_q       <= rsp_err_d;
            rsp_data_q      <= rsp_data_d;
            rsp_addr_q      <= rsp_addr_d;
            mem_rd_q        <= mem_rd_d;
            mem_addr_q      <= mem_addr_d;
            buf_valid_q     <= buf_valid_d;
            buf_addr_q      <= buf_addr_d;
            buf_word_q      <= buf_word_d;
            fetch_addr_q    <= fetch_addr_d;
            word_q          <= word_d;
            cnt_q           <= cnt_d;
            tmo_q           <= tmo_d;
            fetch_flushed_q <= fetch_flushed_d;
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_addr  = rsp_addr_q;
    assign bus.mem_rd    = mem_rd_q;
    assign bus.mem_addr  = mem_addr_q;
endmodule

// File: tb/tb_oc8051_cxrom_fetch_server.sv
// Directed bench for the code-ROM word fetch server: vector table of fetches
// (miss, hit, flush, wrap, timeout) plus hand sequences for backpressure and
// asynchronous reset in the middle of a fetch.
module tb_oc8051_cxrom_fetch_server;
    logic clk;
    logic rst;

    oc8051_cxrom_fetch_server_if bus ();

    oc8051_cxrom_fetch_server #(.TIMEOUT(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] addr;
        int          delay;
        bit          flush_acc;
        bit          flush_mid;
        bit          blk;
        logic [15:0] blk_addr;
        logic [31:0] data;
        bit          err;
        int          reads;
        int          lat;
    } vec_t;

    logic [7:0]  rom [0:65535];
    int          checks = 0;
    int          errors = 0;
    int          ack_delay = 0;
    int          wait_cnt = 0;
    bit          block_en = 1'b0;
    logic [15:0] block_addr = 16'd0;
    logic [15:0] rd_addrs[$];
    vec_t        vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Backing ROM responder: acks after ack_delay wait cycles, never acks block_addr.
    initial begin
        bus.mem_ack     = 1'b0;
        bus.mem_data_in = 8'd0;
        forever begin
            @(negedge clk);
            if (!rst && bus.mem_rd && !(block_en && bus.mem_addr == block_addr)) begin
                if (wait_cnt >= ack_delay) begin
                    bus.mem_ack     = 1'b1;
                    bus.mem_data_in = rom[bus.mem_addr];
                    rd_addrs.push_back(bus.mem_addr);
                    wait_cnt        = 0;
                end else begin
                    bus.mem_ack = 1'b0;
                    wait_cnt++;
                end
            end else begin
                bus.mem_ack = 1'b0;
                wait_cnt    = 0;
            end
        end
    end

    // Present a request, wait (bounded) for rsp_valid; lat counts edges from the accepting one.
    task automatic start_fetch(input logic [15:0] addr, input bit fa, input bit fm, output int lat);
        @(negedge clk);
        chk("req_ready_idle", {31'd0, bus.req_ready}, 32'd1);
        bus.req_valid = 1'b1;
        bus.req_addr  = addr;
        bus.flush     = fa;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.flush     = 1'b0;
        lat = 1;
        while (!bus.rsp_valid && lat < 300) begin
            bus.flush = fm && (lat == 3);
            @(posedge clk);
            #1;
            lat++;
        end
        bus.flush = 1'b0;
        if (!bus.rsp_valid) begin
            errors++;
            checks++;
            $display("FAIL rsp_wait: rsp_valid never rose for addr 0x%0h", addr);
        end
    endtask

    task automatic finish_rsp();
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        chk("rsp_valid_drop", {31'd0, bus.rsp_valid}, 32'd0);
        chk("req_ready_back", {31'd0, bus.req_ready}, 32'd1);
    endtask

    task automatic do_fetch(input vec_t v, input int idx);
        int lat;
        int n;
        ack_delay  = v.delay;
        block_en   = v.blk;
        block_addr = v.blk_addr;
        rd_addrs.delete();
        start_fetch(v.addr, v.flush_acc, v.flush_mid, lat);
        chk("latency", lat, v.lat);
        chk("rsp_data", bus.rsp_data, v.data);
        chk("rsp_err", {31'd0, bus.rsp_err}, {31'd0, v.err});
        chk("rsp_addr", {16'd0, bus.rsp_addr}, {16'd0, v.addr});
        chk("mem_rd_in_resp", {31'd0, bus.mem_rd}, 32'd0);
        finish_rsp();
        n = rd_addrs.size();
        chk("rom_reads", n, v.reads);
        for (int i = 0; i < n && i < v.reads; i++) begin
            chk("rom_addr", {16'd0, rd_addrs[i]}, {16'd0, v.addr + 16'(i)});
        end
        block_en = 1'b0;
        $display("fetch %0d addr=0x%04h data=0x%08h err=%0d lat=%0d reads=%0d",
                 idx, v.addr, bus.rsp_data, bus.rsp_err, lat, n);
    endtask

    initial begin
        vec_t v;
        int   lat;
        for (int i = 0; i < 65536; i++) rom[i] = 8'h00;
        rom[16'h0100] = 8'h11; rom[16'h0101] = 8'h22; rom[16'h0102] = 8'h33; rom[16'h0103] = 8'h44;
        rom[16'hFFFE] = 8'hA1; rom[16'hFFFF] = 8'hB2; rom[16'h0000] = 8'hC3; rom[16'h0001] = 8'hD4;
        rom[16'h0200] = 8'h55; rom[16'h0201] = 8'h66; rom[16'h0202] = 8'h77; rom[16'h0203] = 8'h88;
        rom[16'h0300] = 8'h01; rom[16'h0301] = 8'h02; rom[16'h0302] = 8'h03; rom[16'h0303] = 8'h04;
        rom[16'h0400] = 8'hDE; rom[16'h0401] = 8'hAD; rom[16'h0402] = 8'hBE; rom[16'h0403] = 8'hEF;

        //            addr      dly fa    fm    blk   blk_addr  data          err   rd lat
        vecs[0]  = '{16'h0100, 1, 1'b0, 1'b0, 1'b0, 16'h0000, 32'h44332211, 1'b0, 4, 9};
        vecs[1]  = '{16'h0100, 1, 1'b0, 1'b0, 1'b0, 16'h0000, 32'h44332211, 1'b0, 0, 1};
        vecs[2]  = '{16'h0100, 1, 1'b1, 1'b0, 1'b0, 16'h0000, 32'h44332211, 1'b0, 4, 9};
        vecs[3]  = '{16'h0100, 1, 1'b0, 1'b0, 1'b0, 16'h0000, 32'h44332211, 1'b0, 0, 1};
        vecs[4]  = '{16'hFFFE, 0, 1'b0, 1'b0, 1'b0, 16'h0000, 32'hD4C3B2A1, 1'b0, 4, 5};
        vecs[5]  = '{16'hFFFE, 0, 1'b0, 1'b0, 1'b0, 16'h0000, 32'hD4C3B2A1, 1'b0, 0, 1};
        vecs[6]  = '{16'h0100, 0, 1'b0, 1'b0, 1'b0, 16'h0000, 32'h44332211, 1'b0, 4, 5};
        vecs[7]  = '{16'h0300, 1, 1'b0, 1'b1, 1'b0, 16'h0000, 32'h04030201, 1'b0, 4, 9};
        vecs[8]  = '{16'h0300, 1, 1'b0, 1'b0, 1'b0, 16'h0000, 32'h04030201, 1'b0, 4, 9};
        vecs[9]  = '{16'h0200, 0, 1'b0, 1'b0, 1'b1, 16'h0202, 32'h00000000, 1'b1, 2, 11};
        vecs[10] = '{16'h0300, 0, 1'b0, 1'b0, 1'b0, 16'h0000, 32'h04030201, 1'b0, 0, 1};
        vecs[11] = '{16'h0200, 0, 1'b0, 1'b0, 1'b0, 16'h0000, 32'h88776655, 1'b0, 4, 5};

        rst           = 1'b1;
        bus.flush     = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_addr  = 16'd0;
        bus.rsp_ready = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("rst_rsp_err", {31'd0, bus.rsp_err}, 32'd0);
        chk("rst_rsp_data", bus.rsp_data, 32'd0);
        chk("rst_rsp_addr", {16'd0, bus.rsp_addr}, 32'd0);
        chk("rst_mem_rd", {31'd0, bus.mem_rd}, 32'd0);
        chk("rst_mem_addr", {16'd0, bus.mem_addr}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            do_fetch(vecs[i], i);
        end

        // Backpressure on a hit of 0x0200, with a flush landing while in RESP.
        ack_delay = 0;
        rd_addrs.delete();
        start_fetch(16'h0200, 1'b0, 1'b0, lat);
        chk("bp_hit_latency", lat, 1);
        bus.req_valid = 1'b1;
        bus.req_addr  = 16'h0300;
        for (int i = 0; i < 10; i++) begin
            bus.flush = (i == 3);
            @(posedge clk);
            #1;
            chk("bp_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
            chk("bp_rsp_data", bus.rsp_data, 32'h88776655);
            chk("bp_req_ready", {31'd0, bus.req_ready}, 32'd0);
            chk("bp_mem_rd", {31'd0, bus.mem_rd}, 32'd0);
        end
        bus.flush     = 1'b0;
        bus.req_valid = 1'b0;
        finish_rsp();
        chk("bp_no_reads", rd_addrs.size(), 0);
        $display("backpressure hold: 10 cycles data=0x%08h", bus.rsp_data);
        v = '{16'h0200, 0, 1'b0, 1'b0, 1'b0, 16'h0000, 32'h88776655, 1'b0, 4, 5};
        do_fetch(v, 100);

        // Asynchronous reset mid-fetch clears the buffer and stops ROM traffic at once.
        v = '{16'h0400, 0, 1'b0, 1'b0, 1'b0, 16'h0000, 32'hEFBEADDE, 1'b0, 4, 5};
        do_fetch(v, 101);
        ack_delay = 1;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_addr  = 16'h0500;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        chk("pre_rst_mem_rd", {31'd0, bus.mem_rd}, 32'd1);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("async_rst_mem_rd", {31'd0, bus.mem_rd}, 32'd0);
        chk("async_rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("async_rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("async_rst_mem_addr", {16'd0, bus.mem_addr}, 32'd0);
        $display("async reset mid-fetch: mem_rd=%0d req_ready=%0d", bus.mem_rd, bus.req_ready);
        @(negedge clk);
        rst = 1'b0;
        do_fetch(v, 102);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
